// File: rtl/memory_access_stage.sv
// -----------------------------------------------------------------------------
// memory_access_stage
//
// Execute->memory pipeline register combined with the load/store access unit of
// the pipelined RV32I core. While idle, the M registers capture the execute
// stage every cycle. When the captured op is a load or a store, the block
// issues one request on a req/ack data-memory port and raises StallM until the
// memory acknowledges or the access times out.
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-low reset
//   *E inputs            control/data from the execute pipeline register
//   RegWriteM            write enable to writeback, suppressed while stalled
//   ResultSrcM, RdM,
//   ALUResultM, PCPlus4M registered execute-stage values
//   ReadDataM            aligned load data (zero-extended for byte loads)
//   StallM               access outstanding, freezes F/D/E
//   mem_req/we/addr/
//   wdata/wstrb          request side of the data-memory port
//   mem_ack, mem_rdata   completion pulse and read word from memory
//   mem_error            sticky flag set when an access times out
// -----------------------------------------------------------------------------
module memory_access_stage #(
    parameter int DATA_WIDTH             = 32,
    parameter int REGISTER_ADDRESS_WIDTH = 5,
    parameter int TIMEOUT_CYCLES         = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              RegWriteE,
    input  logic [1:0]                        ResultSrcE,
    input  logic                              MemWriteE,
    input  logic                              ByteAddrE,
    input  logic [DATA_WIDTH-1:0]             ALUResultE,
    input  logic [DATA_WIDTH-1:0]             WriteDataE,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE,
    input  logic [DATA_WIDTH-1:0]             PCPlus4E,
    output logic                              RegWriteM,
    output logic [1:0]                        ResultSrcM,
    output logic [REGISTER_ADDRESS_WIDTH-1:0] RdM,
    output logic [DATA_WIDTH-1:0]             ALUResultM,
    output logic [DATA_WIDTH-1:0]             PCPlus4M,
    output logic [DATA_WIDTH-1:0]             ReadDataM,
    output logic                              StallM,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [DATA_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    output logic [3:0]                        mem_wstrb,
    input  logic                              mem_ack,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    output logic                              mem_error
);

    localparam logic [1:0] RESULT_LOAD = 2'b01;
    localparam int         CNT_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // Byte strobes for a store: one lane for byte stores, all lanes for words.
    function automatic logic [3:0] store_strobe(input logic is_byte, input logic [1:0] offset);
        logic [3:0] strb;
        if (is_byte) begin
            case (offset)
                2'd0:    strb = 4'b0001;
                2'd1:    strb = 4'b0010;
                2'd2:    strb = 4'b0100;
                2'd3:    strb = 4'b1000;
                default: strb = 4'b0000;
            endcase
        end else begin
            strb = 4'b1111;
        end
        return strb;
    endfunction

    // Store data: byte stores replicate the low byte on every lane so the
    // strobe alone selects where it lands.
    function automatic logic [DATA_WIDTH-1:0] store_data(input logic is_byte,
                                                         input logic [DATA_WIDTH-1:0] wdata);
        logic [DATA_WIDTH-1:0] data;
        if (is_byte) begin
            data = DATA_WIDTH'({4{wdata[7:0]}});
        end else begin
            data = wdata;
        end
        return data;
    endfunction

    // Load alignment: byte loads pick the addressed lane and zero-extend it.
    function automatic logic [DATA_WIDTH-1:0] load_align(input logic is_byte,
                                                         input logic [1:0] offset,
                                                         input logic [DATA_WIDTH-1:0] rdata);
        logic [7:0]            lane;
        logic [DATA_WIDTH-1:0] data;
        case (offset)
            2'd0:    lane = rdata[7:0];
            2'd1:    lane = rdata[15:8];
            2'd2:    lane = rdata[23:16];
            2'd3:    lane = rdata[31:24];
            default: lane = 8'h00;
        endcase
        if (is_byte) begin
            data = {{(DATA_WIDTH-8){1'b0}}, lane};
        end else begin
            data = rdata;
        end
        return data;
    endfunction

    state_t                            state_q;
    logic [CNT_W-1:0]                  cnt_q;
    logic                              reg_write_q;
    logic [1:0]                        result_src_q;
    logic                              byte_addr_q;
    logic [REGISTER_ADDRESS_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0]             alu_result_q;
    logic [DATA_WIDTH-1:0]             pc_plus4_q;
    logic [DATA_WIDTH-1:0]             read_data_q;
    logic                              mem_req_q;
    logic                              mem_we_q;
    logic [DATA_WIDTH-1:0]             mem_addr_q;
    logic [DATA_WIDTH-1:0]             mem_wdata_q;
    logic [3:0]                        mem_wstrb_q;
    logic                              mem_error_q;

    logic                              reg_write_d;
    logic [1:0]                        result_src_d;
    logic                              byte_addr_d;
    logic [REGISTER_ADDRESS_WIDTH-1:0] rd_d;
    logic [DATA_WIDTH-1:0]             alu_result_d;
    logic [DATA_WIDTH-1:0]             pc_plus4_d;

    logic                              is_mem_op_s;
    logic                              load_pending_s;
    logic                              stall_s;

    assign stall_s        = (state_q == ST_REQ);
    assign is_mem_op_s    = (ResultSrcE == RESULT_LOAD) || MemWriteE;
    // A store wins if an op were ever flagged as both; only real loads update ReadDataM.
    assign load_pending_s = (result_src_q == RESULT_LOAD) && !mem_we_q;

    // M pipeline registers capture execute values while idle and hold during an access.
    always_comb begin
        reg_write_d  = reg_write_q;
        result_src_d = result_src_q;
        byte_addr_d  = byte_addr_q;
        rd_d         = rd_q;
        alu_result_d = alu_result_q;
        pc_plus4_d   = pc_plus4_q;
        if (state_q == ST_IDLE) begin
            reg_write_d  = RegWriteE;
            result_src_d = ResultSrcE;
            byte_addr_d  = ByteAddrE;
            rd_d         = RdE;
            alu_result_d = ALUResultE;
            pc_plus4_d   = PCPlus4E;
        end else begin
            reg_write_d  = reg_write_q;
            result_src_d = result_src_q;
            byte_addr_d  = byte_addr_q;
            rd_d         = rd_q;
            alu_result_d = alu_result_q;
            pc_plus4_d   = pc_plus4_q;
        end
    end

    // M pipeline register storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            byte_addr_q  <= 1'b0;
            rd_q         <= '0;
            alu_result_q <= '0;
            pc_plus4_q   <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            byte_addr_q  <= byte_addr_d;
            rd_q         <= rd_d;
            alu_result_q <= alu_result_d;
            pc_plus4_q   <= pc_plus4_d;
        end
    end

    // Access FSM: issues the request, counts wait cycles, latches load data or aborts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            read_data_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 4'b0000;
            mem_error_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_mem_op_s) begin
                        state_q    <= ST_REQ;
                        cnt_q      <= '0;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= MemWriteE;
                        mem_addr_q <= {ALUResultE[DATA_WIDTH-1:2], 2'b00};
                        if (MemWriteE) begin
                            mem_wdata_q <= store_data(ByteAddrE, WriteDataE);
                            mem_wstrb_q <= store_strobe(ByteAddrE, ALUResultE[1:0]);
                        end else begin
                            mem_wdata_q <= '0;
                            mem_wstrb_q <= 4'b0000;
                        end
                    end else begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                ST_REQ: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (mem_ack) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        if (load_pending_s) begin
                            read_data_q <= load_align(byte_addr_q, alu_result_q[1:0], mem_rdata);
                        end else begin
                            read_data_q <= read_data_q;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= ST_IDLE;
                        mem_req_q   <= 1'b0;
                        read_data_q <= '0;
                        mem_error_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign StallM     = stall_s;
    assign RegWriteM  = reg_write_q & ~stall_s;
    assign ResultSrcM = result_src_q;
    assign RdM        = rd_q;
    assign ALUResultM = alu_result_q;
    assign PCPlus4M   = pc_plus4_q;
    assign ReadDataM  = read_data_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_error  = mem_error_q;

endmodule
